// File: rtl/ex_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared EX-stage ALU for one
// add per cycle and stalls the pipeline while it owns it.
module ex_mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_go,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_sum,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] product_reg;

  logic in_idle;
  logic in_run;
  logic in_done;
  logic accept;

  assign in_idle = (state_reg == IDLE);
  assign in_run  = (state_reg == RUN);
  assign in_done = (state_reg == DONE);
  assign accept  = in_idle & mul_go & ~flush;

  // Flush must release the ALU and the pipeline in the same cycle it arrives.
  assign alu_own = in_run & ~flush;
  assign alu_a   = alu_own ? acc_reg : '0;
  assign alu_b   = (alu_own & mplier_reg[0]) ? mcand_reg : '0;
  assign stall   = accept | alu_own;
  assign done    = in_done & ~flush;
  assign product = done ? acc_reg : product_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mcand_reg  <= op_a;
            mplier_reg <= op_b;
            acc_reg    <= '0;
            state_reg  <= (op_b == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg    <= alu_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            // Stop as soon as no multiplier bits remain above the current one.
            state_reg  <= (mplier_reg[WIDTH-1:1] == '0) ? DONE : RUN;
          end
        end
        DONE: begin
          if (!flush) begin
            product_reg <= acc_reg;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Directed bench for ex_mul_sequencer with a product/latency scoreboard and
// an ideal adder standing in for the shared EX ALU.
module tb_ex_mul_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_go;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_sum;
  logic         alu_own;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         stall;
  logic         done;
  logic [W-1:0] product;

  always #5 clk = ~clk;

  assign alu_sum = alu_a + alu_b;

  ex_mul_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .mul_go  (mul_go),
    .flush   (flush),
    .op_a    (op_a),
    .op_b    (op_b),
    .alu_sum (alu_sum),
    .alu_own (alu_own),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .stall   (stall),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [W-1:0] prod;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic         s_stall;
  logic         s_own;
  logic         s_done;
  logic [W-1:0] s_b;
  logic [W-1:0] s_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected product from a plain multiply; latency from the multiplier's MSB.
  task automatic expect_op(input logic [W-1:0] a, input logic [W-1:0] b, input int accept_cyc);
    exp_t       e;
    int         n;
    logic [31:0] full;
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    full   = 32'(a) * 32'(b);
    e.prod = full[W-1:0];
    e.due  = accept_cyc + 1 + n;
    sb.push_back(e);
  endtask

  task automatic step(input logic go, input logic fl, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    mul_go = go;
    flush  = fl;
    op_a   = a;
    op_b   = b;
    @(negedge clk);
    s_stall = stall;
    s_own   = alu_own;
    s_done  = done;
    s_b     = alu_b;
    s_prod  = product;
    if (done) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("FAIL spurious_done: observed done=1 product=%0h expected no done (cycle %0d)", product, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("product", 32'(product), 32'(e.prod));
        chk("done_cycle", cyc, e.due);
        $display("txn done cycle=%0d product=%04h expected=%04h", cyc, product, e.prod);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [W-1:0] eb[3];
  int c0;

  initial begin
    rst = 1'b1; mul_go = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_own", 32'(alu_own), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_product", 32'(product), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    step(0, 0, 0, 0);

    // 3 * 5: accept, three RUN cycles with alu_b = 3, 0, 12, then done
    eb[0] = 16'd3; eb[1] = 16'd0; eb[2] = 16'd12;
    expect_op(16'd3, 16'd5, cyc);
    step(1, 0, 16'd3, 16'd5);
    chk("t1_accept_stall", 32'(s_stall), 1);
    chk("t1_accept_own", 32'(s_own), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t1_run_stall", 32'(s_stall), 1);
      chk("t1_run_own", 32'(s_own), 1);
      chk("t1_alu_b", 32'(s_b), 32'(eb[i]));
    end
    step(0, 0, 0, 0);
    chk("t1_done", 32'(s_done), 1);
    chk("t1_done_stall", 32'(s_stall), 0);
    step(0, 0, 0, 0);
    chk("t1_idle_done", 32'(s_done), 0);
    chk("t1_held_product", 32'(s_prod), 16'h000F);

    // multiplier of zero: straight to DONE, ALU never borrowed
    expect_op(16'h1234, 16'h0000, cyc);
    step(1, 0, 16'h1234, 16'h0000);
    chk("t2_accept_own", 32'(s_own), 0);
    chk("t2_accept_stall", 32'(s_stall), 1);
    step(0, 0, 0, 0);
    chk("t2_done", 32'(s_done), 1);
    chk("t2_done_own", 32'(s_own), 0);
    step(0, 0, 0, 0);

    // full-width operands, product truncated to the low 16 bits
    expect_op(16'hFFFF, 16'hFFFF, cyc);
    step(1, 0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0);
      chk("t3_run_own", 32'(s_own), 1);
    end
    step(0, 0, 0, 0);
    chk("t3_done", 32'(s_done), 1);
    step(0, 0, 0, 0);

    // flush on the third RUN cycle squashes the op, product keeps 0x0001
    step(1, 0, 16'd7, 16'h0100);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t4_flush_stall", 32'(s_stall), 0);
    chk("t4_flush_own", 32'(s_own), 0);
    chk("t4_flush_alu_b", 32'(s_b), 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      chk("t4_no_done", 32'(s_done), 0);
      chk("t4_product_kept", 32'(s_prod), 16'h0001);
    end

    // asynchronous reset mid-RUN, between clock edges
    step(1, 0, 16'd5, 16'd3);
    mul_go = 1'b0;
    #1;
    chk("t5_pre_rst_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_stall", 32'(stall), 0);
    chk("t5_rst_own", 32'(alu_own), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_product", 32'(product), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc++;
    step(0, 0, 0, 0);
    chk("t5_after_rst_stall", 32'(s_stall), 0);

    // back-to-back 2*3 then 4*4 with mul_go held through DONE
    c0 = cyc;
    expect_op(16'd2, 16'd3, c0);
    expect_op(16'd4, 16'd4, c0 + 4);
    step(1, 0, 16'd2, 16'd3);
    step(1, 0, 16'd4, 16'd4);
    step(1, 0, 16'd4, 16'd4);
    step(1, 0, 16'd4, 16'd4);
    chk("t6_done_a", 32'(s_done), 1);
    chk("t6_done_a_stall", 32'(s_stall), 0);
    step(1, 0, 16'd4, 16'd4);
    chk("t6_reaccept_stall", 32'(s_stall), 1);
    chk("t6_reaccept_product", 32'(s_prod), 16'd6);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("t6_final_product", 32'(s_prod), 16'h0010);

    chk("sb_outstanding", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
